buffer_fifo: RTL and testbench

//   Parametrised, registered successor to the single-bit pass-through buffer.

---
 rtl/buffer_fifo.sv | 73 +++++++
 tb/tb_buffer_fifo.sv | 119 +++++++++++
 2 files changed

// File: rtl/buffer_fifo.sv
// Show-ahead FIFO with ready/valid on both sides, fill count, almost-full,
// synchronous flush and a sticky overflow-attempt flag.
module buffer_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                           Clock,
  input  logic                           nReset,
  input  logic                           Flush,
  input  logic [WIDTH-1:0]               In_Data,
  input  logic                           In_Valid,
  output logic                           In_Ready,
  output logic [WIDTH-1:0]               Out_Data,
  output logic                           Out_Valid,
  input  logic                           Out_Ready,
  output logic [$clog2(DEPTH+1)-1:0]     Count,
  output logic                           Almost_Full,
  output logic                           Overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             push, pop;

  // Status flags come only from the registered count, so no ready/valid
  // path runs combinationally through the buffer.
  assign In_Ready    = (cnt != FULL_CNT);
  assign Out_Valid   = (cnt != '0);
  assign Almost_Full = (cnt >= AFULL_CNT);
  assign Count       = cnt;
  assign Overflow    = ovf;
  assign Out_Data    = mem[rd_ptr];

  assign push = In_Valid  & In_Ready  & ~Flush;
  assign pop  = Out_Valid & Out_Ready & ~Flush;

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= In_Data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (In_Valid && !In_Ready) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_buffer_fifo.sv
// Directed plus randomized bench for buffer_fifo; a queue model at negedge
// predicts every status output and the head word.
module tb_buffer_fifo;
  localparam int WIDTH = 8, DEPTH = 4, AFULL_LVL = 3;
  localparam int CW = $clog2(DEPTH+1);

  logic             Clock = 0, nReset = 0, Flush = 0;
  logic [WIDTH-1:0] In_Data = '0;
  logic             In_Valid = 0, Out_Ready = 0;
  logic             In_Ready, Out_Valid, Almost_Full, Overflow;
  logic [WIDTH-1:0] Out_Data;
  logic [CW-1:0]    Count;

  int checks = 0, errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_ovf = 0;

  buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
    .Clock(Clock), .nReset(nReset), .Flush(Flush),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Count(Count), .Almost_Full(Almost_Full), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard: compare against the model, then advance the model
  // by what the upcoming rising edge will do with the currently driven inputs.
  always @(negedge Clock) begin
    int sz;
    bit do_push, do_pop;
    if (!nReset) begin
      exp_q.delete();
      exp_ovf = 0;
    end
    sz = exp_q.size();
    chk("count",       32'(Count),       32'(sz));
    chk("in_ready",    32'(In_Ready),    32'(sz < DEPTH));
    chk("out_valid",   32'(Out_Valid),   32'(sz > 0));
    chk("almost_full", 32'(Almost_Full), 32'(sz >= AFULL_LVL));
    chk("overflow",    32'(Overflow),    32'(exp_ovf));
    if (sz > 0) chk("out_data", 32'(Out_Data), 32'(exp_q[0]));
    if (nReset) begin
      if (Flush) begin
        exp_q.delete();
        exp_ovf = 0;
      end else begin
        do_pop  = (sz > 0) && Out_Ready;
        do_push = In_Valid && (sz < DEPTH);
        if (In_Valid && sz == DEPTH) exp_ovf = 1;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(In_Data);
      end
    end
  end

  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    In_Valid = v; In_Data = d; Out_Ready = r; Flush = f;
    @(posedge Clock); #1;
  endtask

  initial begin
    repeat (2) @(posedge Clock);
    #1 nReset = 1;

    // fill to full without popping, then drain in order
    cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0); cyc(1, 8'h44, 0, 0);
    cyc(0, 8'h00, 0, 0);
    repeat (4) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);

    // streaming: simultaneous push/pop, pointers wrap twice
    for (int i = 0; i < 10; i++) cyc(1, 8'(i), 1, 0);
    repeat (2) cyc(0, 8'h00, 1, 0);

    // overflow attempt on full, then flush
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hA0 + i), 0, 0);
    cyc(1, 8'hAA, 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0);

    // flush wins over simultaneous push and pop
    cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h55, 1, 1);
    cyc(0, 8'h00, 0, 0);

    // async reset between edges with 3 words held
    cyc(1, 8'h61, 0, 0); cyc(1, 8'h62, 0, 0); cyc(1, 8'h63, 0, 0);
    In_Valid = 0; Out_Ready = 0; Flush = 0;
    #1 nReset = 0;
    #1;
    chk("rst_out_valid", 32'(Out_Valid), 32'd0);
    chk("rst_count",     32'(Count),     32'd0);
    chk("rst_in_ready",  32'(In_Ready),  32'd1);
    @(posedge Clock); #1 nReset = 1;
    cyc(1, 8'h7E, 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);

    // randomized traffic with occasional flush
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 99) < 60), 8'($urandom),
          1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 31) == 0));

    cyc(0, 8'h00, 0, 0);
    @(negedge Clock); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
